// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch front end: reset defaults,
// FSM state encoding and the FIFO entry layout.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; 32-bit add wraps naturally at the top of memory.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift-style FIFO of {pc, instr}; the head entry is always a
// register so downstream never sees a combinational path from memory.
module fetch_fifo
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic         full,
    output logic         empty
);

    fetch_entry_t head_r, tail_r, head_next_s, tail_next_s;
    logic         head_vld_r, tail_vld_r, head_vld_next_s, tail_vld_next_s;

    // Next-state for the two slots; a pop shifts the tail into the head.
    always_comb begin
        head_next_s     = head_r;
        tail_next_s     = tail_r;
        head_vld_next_s = head_vld_r;
        tail_vld_next_s = tail_vld_r;
        if (flush) begin
            head_vld_next_s = 1'b0;
            tail_vld_next_s = 1'b0;
        end else if (push && pop) begin
            if (tail_vld_r) begin
                head_next_s = tail_r;
                tail_next_s = din;
            end else begin
                head_next_s     = din;
                head_vld_next_s = 1'b1;
            end
        end else if (push) begin
            if (!head_vld_r) begin
                head_next_s     = din;
                head_vld_next_s = 1'b1;
            end else if (!tail_vld_r) begin
                tail_next_s     = din;
                tail_vld_next_s = 1'b1;
            end else begin
                tail_next_s = tail_r;
            end
        end else if (pop) begin
            if (tail_vld_r) begin
                head_next_s     = tail_r;
                tail_vld_next_s = 1'b0;
            end else begin
                head_vld_next_s = 1'b0;
            end
        end else begin
            head_next_s = head_r;
        end
    end

    // Slot storage and valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r     <= '0;
            tail_r     <= '0;
            head_vld_r <= 1'b0;
            tail_vld_r <= 1'b0;
        end else begin
            head_r     <= head_next_s;
            tail_r     <= tail_next_s;
            head_vld_r <= head_vld_next_s;
            tail_vld_r <= tail_vld_next_s;
        end
    end

    assign head       = head_r;
    assign head_valid = head_vld_r;
    assign full       = tail_vld_r;
    assign empty      = ~head_vld_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, RUN/HALT control and a 2-entry output
// buffer, with redirect flush and halt-on-magic-word.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    logic [31:0]  pc_r, pc_next_s;
    fetch_state_t state_r, state_next_s;
    fetch_entry_t push_entry_s, head_s;
    logic         fire_s, pop_s, full_s, empty_s, head_valid_s;

    assign pop_s        = head_valid_s & out_ready;
    assign push_entry_s = '{pc: pc_r, instr: imem_instr};

    // Fetch decision, next PC and next FSM state; redirect overrides everything.
    always_comb begin
        fire_s       = 1'b0;
        pc_next_s    = pc_r;
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (!redirect_valid && (!full_s || pop_s)) begin
                    fire_s = 1'b1;
                end else begin
                    fire_s = 1'b0;
                end
            end
            ST_HALT: fire_s = 1'b0;
            default: fire_s = 1'b0;
        endcase
        if (redirect_valid) begin
            pc_next_s    = word_align(redirect_pc);
            state_next_s = ST_RUN;
        end else if (fire_s) begin
            pc_next_s = pc_plus4(pc_r);
            if (imem_instr == HALT_WORD) begin
                state_next_s = ST_HALT;
            end else begin
                state_next_s = state_r;
            end
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            state_r <= ST_RUN;
        end else begin
            pc_r    <= pc_next_s;
            state_r <= state_next_s;
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fire_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .din        (push_entry_s),
        .head       (head_s),
        .head_valid (head_valid_s),
        .full       (full_s),
        .empty      (empty_s)
    );

    assign imem_addr = pc_r;
    assign out_valid = head_valid_s & ~empty_s;
    assign out_instr = head_s.instr;
    assign out_pc    = head_s.pc;
    assign halted    = (state_r == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: halt program, back-pressure, redirect,
// PC wrap (second instance) and asynchronous mid-cycle reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] imem_addr, imem_instr, out_instr, out_pc;
    logic        out_valid, halted;
    logic [31:0] w_addr, w_instr_in, w_instr, w_pc;
    logic        w_valid, w_halted;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2001_0003;
            32'h0000_0004: return 32'h2002_0004;
            32'h0000_0008: return 32'h0022_1820;
            32'h0000_000C: return 32'h0000_0000;
            32'h0000_0010: return 32'hFC00_0000;
            default:       return {16'hA000, a[15:0]};
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);
    assign w_instr_in = mem_word(w_addr);

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_instr(w_instr_in),
        .out_valid(w_valid), .out_ready(out_ready), .out_instr(w_instr),
        .out_pc(w_pc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(w_halted)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step();
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_pc", out_pc, 32'h0);
        check_val("rst_instr", out_instr, 32'h0);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("rst_w_addr", w_addr, 32'hFFFF_FFFC);
        check_val("rst_w_halted", {31'd0, w_halted}, 32'd0);

        // Halt program with continuous acceptance
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_val("p0_valid", {31'd0, out_valid}, 32'd1);
        check_val("p0_pc", out_pc, 32'h0);
        check_val("p0_instr", out_instr, 32'h2001_0003);
        check_val("w0_valid", {31'd0, w_valid}, 32'd1);
        check_val("w0_pc", w_pc, 32'hFFFF_FFFC);
        check_val("w0_instr", w_instr, 32'hA000_FFFC);
        step();
        check_val("p4_pc", out_pc, 32'h4);
        check_val("p4_instr", out_instr, 32'h2002_0004);
        check_val("w1_pc", w_pc, 32'h0);
        check_val("w1_instr", w_instr, 32'h2001_0003);
        step();
        check_val("p8_pc", out_pc, 32'h8);
        check_val("p8_instr", out_instr, 32'h0022_1820);
        check_val("p8_halted", {31'd0, halted}, 32'd0);
        step();
        check_val("pC_pc", out_pc, 32'hC);
        check_val("pC_instr", out_instr, 32'h0);
        step();
        check_val("p10_pc", out_pc, 32'h10);
        check_val("p10_instr", out_instr, 32'hFC00_0000);
        check_val("p10_halted", {31'd0, halted}, 32'd1);
        step();
        check_val("drain_valid", {31'd0, out_valid}, 32'd0);
        check_val("halt_addr", imem_addr, 32'h14);
        check_val("halt_stay", {31'd0, halted}, 32'd1);
        step();
        check_val("no_p14", {31'd0, out_valid}, 32'd0);

        // Redirect out of HALT
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check_val("rd_halted", {31'd0, halted}, 32'd0);
        check_val("rd_valid", {31'd0, out_valid}, 32'd0);
        check_val("rd_addr", imem_addr, 32'h0);
        out_ready = 1'b0;
        step();
        check_val("rd_p0_valid", {31'd0, out_valid}, 32'd1);
        check_val("rd_p0_pc", out_pc, 32'h0);
        step();
        step();
        check_val("full_hold_pc", out_pc, 32'h0);
        check_val("full_hold_addr", imem_addr, 32'h8);

        // Asynchronous reset between edges with two entries buffered
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", {31'd0, out_valid}, 32'd0);
        check_val("arst_halted", {31'd0, halted}, 32'd0);
        check_val("arst_addr", imem_addr, 32'h0);

        // Back-pressure for 5 cycles after reset release
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_val("bp_valid", {31'd0, out_valid}, 32'd1);
        check_val("bp_pc", out_pc, 32'h0);
        check_val("bp_instr", out_instr, 32'h2001_0003);
        check_val("bp_addr", imem_addr, 32'h8);
        out_ready = 1'b1;
        step();
        check_val("bp_pop4", out_pc, 32'h4);
        step();
        check_val("bp_pop8", out_pc, 32'h8);
        check_val("bp_pop8_instr", out_instr, 32'h0022_1820);

        // Redirect while full
        out_ready = 1'b0;
        step();
        check_val("pre_rd_addr", imem_addr, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0042;
        step();
        redirect_valid = 1'b0;
        check_val("fl_valid", {31'd0, out_valid}, 32'd0);
        check_val("fl_addr", imem_addr, 32'h40);
        out_ready = 1'b1;
        step();
        check_val("fl_p40_valid", {31'd0, out_valid}, 32'd1);
        check_val("fl_p40_pc", out_pc, 32'h40);
        check_val("fl_p40_instr", out_instr, 32'hA000_0040);
        step();
        check_val("fl_p44_pc", out_pc, 32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
